// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } ifetch_state_e;

  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs; flush wins over push.
module ifetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    count    = count_q;
    rdata    = mem_q[rd_ptr_q];
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    do_push  = push && !flush && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC ownership, memory request issue, response buffering, redirect flush.
// Optional IFETCH_ALIGN_CHECK_EN adds a sticky FetchFault on misaligned redirects.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddress,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemReqAddress,
  input  logic        MemRespValid,
  input  logic [31:0] MemRespData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic        FetchFault,
`endif
  output logic [31:0] InstrPC
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  ifetch_state_e state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] inflight;
  logic [31:0]   redir_addr;
  logic          req_fire, resp_fire, pop, push, flush, issue_block;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_rdata;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic          fault_q, fault_d;
`endif

  always_comb begin
    issue_block = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    issue_block = fault_q;
`endif
    InstrValid    = !fifo_empty;
    InstrPC       = fifo_rdata[63:32];
    Instr         = fifo_rdata[31:0];
    // Outstanding + occupancy only shrinks without a handshake, so a raised request stays raised.
    MemReqValid   = (state_q == FETCH) && !issue_block && !fifo_full &&
                    (({1'b0, out_q} + {1'b0, fifo_count}) < DEPTH_L);
    MemReqAddress = fetch_pc_q;
    req_fire      = MemReqValid && MemReqReady;
    resp_fire     = MemRespValid;
    pop           = InstrValid && InstrReady;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    push       = 1'b0;
    flush      = 1'b0;
    inflight   = out_q + drop_q + CW'(req_fire) - CW'(resp_fire);
`ifdef IFETCH_ALIGN_CHECK_EN
    fault_d    = fault_q;
    redir_addr = RedirectAddress;
`else
    redir_addr = RedirectAddress & ~32'h3;
`endif

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + WORD_BYTES;
      out_d      = out_q + CW'(1);
    end
    if (resp_fire) begin
      if (state_q == FLUSH) begin
        drop_d = drop_q - CW'(1);
      end else begin
        push      = 1'b1;
        resp_pc_d = resp_pc_q + WORD_BYTES;
        out_d     = out_d - CW'(1);
      end
    end

    case (state_q)
      IDLE:    state_d = FETCH;
      FLUSH:   if (drop_d == '0) state_d = FETCH;
      default: state_d = state_q;
    endcase

    // Every request still owed a response after this edge becomes a response to discard.
    if (Redirect) begin
      push       = 1'b0;
      flush      = 1'b1;
      fetch_pc_d = redir_addr;
      resp_pc_d  = redir_addr;
      out_d      = '0;
      drop_d     = inflight;
      state_d    = (inflight != '0) ? FLUSH : FETCH;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (RedirectAddress[1:0] != 2'b00) fault_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  always_comb FetchFault = fault_q;
`endif

  ifetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk  (Clock),
    .rst  (Reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata({resp_pc_q, MemRespData}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

endmodule
